// File: rtl/pm_pkg.sv
// pm_pkg: shared definitions for the parking-meter timer credit scheduler.
// It holds the FSM state encoding, the credit each coin type is worth, the
// number of credit lamps and a thermometer-code helper for those lamps.
package pm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } pm_state_t;

    localparam int COIN_H_CREDIT = 1;  // 50c coin buys one timer cycle
    localparam int COIN_D_CREDIT = 2;  // 100c coin buys two timer cycles
    localparam int LAMP_N        = 4;  // lamps on the credit bar

    // Thermometer code: lamp i is lit while credit exceeds i.
    function automatic logic [LAMP_N-1:0] lamp_code(input int unsigned credit_val);
        logic [LAMP_N-1:0] lamps;
        lamps = '0;
        for (int unsigned i = 0; i < LAMP_N; i++) begin
            lamps[i] = (credit_val > i);
        end
        return lamps;
    endfunction

endpackage

// File: rtl/pm_coin_edge.sv
// pm_coin_edge: rising-edge detector for the two coin sensors.
// A coin counts once, on the clock where its sensor goes from 0 to 1, and
// only if the Start button is held (i_s=1) and the scheduler accepts coins.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_s         Start button level (coins gated by it)
//   i_en        coin acceptance enable (low while the scheduler is faulted)
//   i_h, i_d    50c / 100c coin sensor levels
//   o_add       credit to add this clock, 0..3
module pm_coin_edge
    import pm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_s,
    input  logic       i_en,
    input  logic       i_h,
    input  logic       i_d,
    output logic [1:0] o_add
);

    logic r_h_q;
    logic r_d_q;
    logic w_h_rise;
    logic w_d_rise;

    // Sensor history keeps tracking even while coins are not accepted, so a
    // sensor already high when acceptance resumes is not counted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_q <= 1'b0;
            r_d_q <= 1'b0;
        end else begin
            r_h_q <= i_h;
            r_d_q <= i_d;
        end
    end

    assign w_h_rise = i_h & ~r_h_q & i_s & i_en;
    assign w_d_rise = i_d & ~r_d_q & i_s & i_en;

    assign o_add = (w_h_rise ? 2'(COIN_H_CREDIT) : 2'd0)
                 + (w_d_rise ? 2'(COIN_D_CREDIT) : 2'd0);

endmodule

// File: rtl/pm_timer_sched.sv
// pm_timer_sched: credit scheduler for the parking meter's external timer.
// Coins build up credit; once Start is released each credit is spent on one
// run of the shared countdown timer, and runs are chained back to back
// until the credit is gone.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   s           Start button level; coins accepted only while s=1
//   h, d        50c / 100c coin sensor levels
//   t           timer busy, active low (idles 1, 0 while running)
//   ct          one-clock timer start strobe
//   p           paid: credit left or a timer run in progress
//   rej         one-clock pulse when an accepted coin hits the credit limit
//   fault       sticky: timer never acknowledged a start strobe
//   L           credit lamps, thermometer code
//   credit      current credit count
//   state       encoded FSM state (pm_state_t)
//
// Timer handshake: ct is a single-clock request. The timer acknowledges by
// pulling t low; the run ends when t returns high. A request that sees no
// low t within ACK_TIMEOUT clocks locks the block in FAULT until reset.
// t is only looked at while waiting for the acknowledge or for the end of
// the run, so low glitches in any other state are ignored.
module pm_timer_sched
    import pm_pkg::*;
#(
    parameter int MAX_CREDIT  = 8,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic              h,
    input  logic              d,
    input  logic              t,
    output logic              ct,
    output logic              p,
    output logic              rej,
    output logic              fault,
    output logic [LAMP_N-1:0] L,
    output logic [CNT_W-1:0]  credit,
    output logic [2:0]        state
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int SUM_W = CNT_W + 1;

    pm_state_t        r_state;
    pm_state_t        w_state_nxt;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [ACK_W-1:0] w_ack_cnt_nxt;
    logic [CNT_W-1:0] r_credit;
    logic [CNT_W-1:0] w_credit_nxt;
    logic             r_ct;
    logic             r_rej;
    logic             w_dec;
    logic [1:0]       w_add;
    logic [SUM_W-1:0] w_sum;
    logic             w_over;
    logic             w_rej_nxt;
    logic             w_coin_en;

    // Coins are ignored once the block has faulted.
    assign w_coin_en = (r_state != ST_FAULT);

    pm_coin_edge u_coin_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .i_s   (s),
        .i_en  (w_coin_en),
        .i_h   (h),
        .i_d   (d),
        .o_add (w_add)
    );

    // Next state; w_dec marks the clocks that spend one credit on a start.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_cnt_nxt = r_ack_cnt;
        w_dec         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Nothing is dispensed while Start is still held.
                if (r_credit != '0 && !s) begin
                    w_state_nxt = ST_START;
                    w_dec       = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt   = ST_WAIT_ACK;
                w_ack_cnt_nxt = '0;
            end
            ST_WAIT_ACK: begin
                if (!t) begin
                    w_state_nxt = ST_RUN;
                end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (t) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Chained runs do not wait for Start to be released again.
                if (r_credit != '0) begin
                    w_state_nxt = ST_START;
                    w_dec       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One spare bit so credit + 3 cannot wrap before the saturation test.
    // w_dec is only set with credit > 0, so the subtraction never borrows.
    assign w_sum        = {1'b0, r_credit} + SUM_W'(w_add) - SUM_W'(w_dec);
    assign w_over       = (w_sum > SUM_W'(MAX_CREDIT));
    assign w_credit_nxt = w_over ? CNT_W'(MAX_CREDIT) : w_sum[CNT_W-1:0];
    assign w_rej_nxt    = w_over & (w_add != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ack_cnt <= '0;
            r_credit  <= '0;
            r_ct      <= 1'b0;
            r_rej     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack_cnt <= w_ack_cnt_nxt;
            r_credit  <= w_credit_nxt;
            // Strobe is registered off START, so it shows one clock later.
            r_ct      <= (r_state == ST_START);
            r_rej     <= w_rej_nxt;
        end
    end

    assign ct     = r_ct;
    assign rej    = r_rej;
    assign fault  = (r_state == ST_FAULT);
    assign p      = (r_credit != '0)
                  | (r_state inside {ST_START, ST_WAIT_ACK, ST_RUN, ST_DONE});
    assign L      = lamp_code(32'(r_credit));
    assign credit = r_credit;
    assign state  = r_state;

endmodule

// File: tb/tb_pm_timer_sched.sv
module tb_pm_timer_sched;

    localparam int MAXC = 8;
    localparam int ACKT = 8;
    localparam int CW   = 4;

    logic          clk;
    logic          rst_n;
    logic          s;
    logic          h;
    logic          d;
    logic          t;
    logic          ct;
    logic          p;
    logic          rej;
    logic          fault;
    logic [3:0]    L;
    logic [CW-1:0] credit;
    logic [2:0]    state;

    pm_timer_sched #(
        .MAX_CREDIT  (MAXC),
        .ACK_TIMEOUT (ACKT),
        .CNT_W       (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (s),
        .h      (h),
        .d      (d),
        .t      (t),
        .ct     (ct),
        .p      (p),
        .rej    (rej),
        .fault  (fault),
        .L      (L),
        .credit (credit),
        .state  (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    bit sb_en    = 0;
    int ct_cnt   = 0;
    int rej_cnt  = 0;
    logic [CW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle-level behaviour of the meter written from the rules: credit as a
    // plain integer, states as the published numbers 0..5.
    int m_state  = 0;
    int m_credit = 0;
    int m_wait   = 0;
    int m_ct     = 0;
    int m_rej    = 0;
    bit m_hq     = 0;
    bit m_dq     = 0;
    int mm_add;
    int mm_sum;
    int mm_go;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state  = 0;
            m_credit = 0;
            m_wait   = 0;
            m_ct     = 0;
            m_rej    = 0;
            m_hq     = 0;
            m_dq     = 0;
        end else begin
            mm_add = 0;
            if (m_state != 5 && s) begin
                if (h && !m_hq) mm_add += 1;
                if (d && !m_dq) mm_add += 2;
            end
            mm_go = (m_credit > 0 && ((m_state == 0 && !s) || m_state == 4)) ? 1 : 0;
            mm_sum   = m_credit + mm_add - mm_go;
            m_rej    = (mm_sum > MAXC && mm_add > 0) ? 1 : 0;
            m_credit = (mm_sum > MAXC) ? MAXC : mm_sum;
            m_ct     = (m_state == 1) ? 1 : 0;
            case (m_state)
                0: if (mm_go != 0) m_state = 1;
                1: begin m_state = 2; m_wait = 0; end
                2: begin
                    if (!t) m_state = 3;
                    else begin
                        m_wait++;
                        if (m_wait == ACKT) m_state = 5;
                    end
                end
                3: if (t) m_state = 4;
                4: m_state = (mm_go != 0) ? 1 : 0;
                default: ;
            endcase
            m_hq = h;
            m_dq = d;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int exp_l;
    int exp_p;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_l = (1 << ((m_credit > 4) ? 4 : m_credit)) - 1;
            exp_p = (m_credit != 0 || (m_state >= 1 && m_state <= 4)) ? 1 : 0;
            chk("state",  32'(state),  m_state);
            chk("credit", 32'(credit), m_credit);
            chk("ct",     32'(ct),     m_ct);
            chk("rej",    32'(rej),    m_rej);
            chk("fault",  32'(fault),  (m_state == 5) ? 1 : 0);
            chk("p",      32'(p),      exp_p);
            chk("lamps",  32'(L),      exp_l);
        end
        if (ct) ct_cnt++;
        if (rej) rej_cnt++;
        if (ct && sb_en) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ct", 32'(credit), 32'hFFFF_FFFF);
            end else begin
                chk("sb_credit_at_ct", 32'(credit), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- external timer model ----------------
    bit tmr_dead = 0;
    bit tmr_rnd  = 0;
    int tmr_dly  = 1;
    int tmr_hold = 3;
    int tm_dly;
    int tm_hold;

    initial begin
        t = 1'b1;
        forever begin
            @(negedge clk);
            if (ct && !tmr_dead) begin
                tm_dly  = tmr_rnd ? $urandom_range(1, 5) : tmr_dly;
                tm_hold = tmr_rnd ? $urandom_range(1, 6) : tmr_hold;
                repeat (tm_dly) @(negedge clk);
                t = 1'b0;
                repeat (tm_hold) @(negedge clk);
                t = 1'b1;
            end else if (tmr_rnd && (m_state == 0 || m_state == 4) &&
                         $urandom_range(0, 7) == 0) begin
                // Stray low on t where it must be ignored.
                t = 1'b0;
                @(negedge clk);
                t = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic coin(input bit is_d);
        if (is_d) d = 1'b1;
        else h = 1'b1;
        cyc(1);
        h = 1'b0;
        d = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!(state == 3'd0 && credit == '0 && t == 1'b1) && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, (k < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_state(input string tag, input int st, input int budget);
        int k;
        k = 0;
        while (32'(state) != st && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, (k < budget) ? 1 : 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        s = 1'b0;
        h = 1'b0;
        d = 1'b0;
        do_reset();
        chk_en = 1;

        // Reset values
        chk("rst_state", 32'(state), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_ct", 32'(ct), 0);
        chk("rst_p", 32'(p), 0);
        chk("rst_rej", 32'(rej), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_lamps", 32'(L), 0);

        // 1: single 50c
        ct_cnt = 0;
        s = 1'b1;
        coin(0);
        chk("t1_credit", 32'(credit), 1);
        chk("t1_lamps", 32'(L), 4'b0001);
        s = 1'b0;
        wait_idle("t1_idle", 100);
        chk("t1_ct_count", ct_cnt, 1);
        chk("t1_lamps_end", 32'(L), 0);
        chk("t1_p_end", 32'(p), 0);

        // 2: two 100c coins, then four chained runs
        ct_cnt = 0;
        s = 1'b1;
        coin(1);
        coin(1);
        chk("t2_credit", 32'(credit), 4);
        chk("t2_lamps", 32'(L), 4'b1111);
        cyc(3);
        chk("t2_no_ct_held", ct_cnt, 0);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        sb_en = 1;
        s = 1'b0;
        wait_idle("t2_idle", 300);
        sb_en = 0;
        chk("t2_ct_count", ct_cnt, 4);
        chk("t2_sb_left", exp_q.size(), 0);

        // 3: saturation
        do_reset();
        ct_cnt = 0;
        rej_cnt = 0;
        s = 1'b1;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd8);
        for (int i = 0; i < 5; i++) begin
            coin(1);
            chk("t3_credit", 32'(credit), 32'(exp_q.pop_front()));
        end
        chk("t3_rej_count", rej_cnt, 1);
        s = 1'b0;
        wait_idle("t3_idle", 600);
        chk("t3_ct_count", ct_cnt, 8);

        // 4: coin lands on the same clock as DONE->START
        do_reset();
        ct_cnt = 0;
        rej_cnt = 0;
        s = 1'b1;
        coin(0);
        coin(0);
        s = 1'b0;
        wait_state("t4_reach_done", 4, 60);
        s = 1'b1;
        h = 1'b1;
        cyc(1);
        chk("t4_credit_net0", 32'(credit), 1);
        chk("t4_state_start", 32'(state), 1);
        h = 1'b0;
        s = 1'b0;
        cyc(1);
        chk("t4_rej_count", rej_cnt, 0);
        wait_idle("t4_idle", 200);
        chk("t4_ct_count", ct_cnt, 3);

        // 5: dead timer
        do_reset();
        ct_cnt = 0;
        rej_cnt = 0;
        tmr_dead = 1;
        s = 1'b1;
        coin(0);
        coin(0);
        s = 1'b0;
        wait_state("t5_reach_fault", 5, 40);
        chk("t5_fault", 32'(fault), 1);
        chk("t5_credit", 32'(credit), 1);
        s = 1'b1;
        coin(0);
        coin(1);
        cyc(10);
        chk("t5_credit_frozen", 32'(credit), 1);
        chk("t5_ct_count", ct_cnt, 1);
        chk("t5_state_stuck", 32'(state), 5);
        s = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_state", 32'(state), 0);
        chk("t5_async_fault", 32'(fault), 0);
        chk("t5_async_credit", 32'(credit), 0);
        chk("t5_async_p", 32'(p), 0);
        chk("t5_async_lamps", 32'(L), 0);
        chk("t5_async_ct", 32'(ct), 0);
        cyc(1);
        rst_n = 1'b1;
        tmr_dead = 0;
        cyc(1);

        // 6: Start held through 100c+50c+100c
        ct_cnt = 0;
        s = 1'b1;
        coin(1);
        coin(0);
        coin(1);
        chk("t6_credit", 32'(credit), 5);
        chk("t6_lamps", 32'(L), 4'b1111);
        chk("t6_no_ct_held", ct_cnt, 0);
        s = 1'b0;
        wait_idle("t6_idle", 400);
        chk("t6_ct_count", ct_cnt, 5);
        s = 1'b1;
        coin(0);
        s = 1'b0;
        wait_idle("t6_idle2", 100);
        chk("t6_ct_count2", ct_cnt, 6);

        // Randomized bursts, every cycle compared against the model
        tmr_rnd = 1;
        for (int b = 0; b < 4; b++) begin
            do_reset();
            tmr_dead = (b == 2);
            for (int c = 0; c < 250; c++) begin
                if (c % 16 == 0) s = ($urandom_range(0, 2) != 0);
                h = ($urandom_range(0, 3) == 0);
                d = ($urandom_range(0, 3) == 0);
                cyc(1);
            end
            s = 1'b0;
            h = 1'b0;
            d = 1'b0;
            if (tmr_dead) cyc(20);
            else wait_idle("rnd_idle", 1000);
        end
        tmr_dead = 0;
        tmr_rnd = 0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
